// File: rtl/image_frame_store.sv
// rtl/image_frame_store.sv - 64x64 pixel frame buffer with load/run/dump sequencing for the processing core
module image_frame_store #(
    parameter int PIX_W   = 24,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [PIX_W-1:0] ld_pix,
    output logic             dp_valid,
    input  logic             dp_ready,
    output logic [PIX_W-1:0] dp_pix,
    output logic             dp_last,
    input  logic [5:0]       row,
    input  logic [5:0]       col,
    output logic [PIX_W-1:0] in_pix,
    input  logic             out_we,
    input  logic [PIX_W-1:0] out_pix,
    input  logic             mirror_done,
    input  logic             gray_done,
    input  logic             filter_done,
    output logic             proc_rst_n,
    output logic [2:0]       stage_flags,
    output logic             timeout_err,
    output logic             busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DUMP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [15:0] RUN_LAST = 16'(TIMEOUT - 1);
    localparam logic [11:0] ADDR_LAST = 12'hFFF;

    logic [PIX_W-1:0] mem [0:4095];

    logic [2:0]       state_q, state_d;
    logic [11:0]      ld_addr_q, ld_addr_d;
    logic [11:0]      dp_addr_q, dp_addr_d;
    logic [15:0]      run_cnt_q, run_cnt_d;
    logic [PIX_W-1:0] dp_pix_q, dp_pix_d;
    logic             dp_vld_q, dp_vld_d;
    logic [2:0]       flags_q, flags_d;
    logic             tmo_q, tmo_d;

    logic             mem_we;
    logic [11:0]      mem_waddr;
    logic [PIX_W-1:0] mem_wdata;
    logic [11:0]      dp_next;

    assign dp_next = dp_addr_q + 12'd1;

    // Core reads are combinational; a same-cycle write lands at the edge, so the read sees old data.
    assign in_pix      = mem[{row, col}];
    assign ld_ready    = (state_q == S_LOAD);
    assign proc_rst_n  = (state_q == S_RUN);
    assign busy        = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DUMP);
    assign dp_valid    = dp_vld_q;
    assign dp_last     = dp_vld_q && (dp_addr_q == ADDR_LAST);
    assign dp_pix      = dp_pix_q;
    assign stage_flags = flags_q;
    assign timeout_err = tmo_q;

    always_comb begin
        state_d   = state_q;
        ld_addr_d = ld_addr_q;
        dp_addr_d = dp_addr_q;
        run_cnt_d = run_cnt_q;
        dp_pix_d  = dp_pix_q;
        dp_vld_d  = dp_vld_q;
        flags_d   = flags_q;
        tmo_d     = tmo_q;
        mem_we    = 1'b0;
        mem_waddr = ld_addr_q;
        mem_wdata = ld_pix;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    ld_addr_d = 12'd0;
                    flags_d   = 3'b000;
                    tmo_d     = 1'b0;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    ld_addr_d = ld_addr_q + 12'd1;
                    if (ld_addr_q == ADDR_LAST) begin
                        state_d   = S_RUN;
                        run_cnt_d = 16'd0;
                    end
                end
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + 16'd1;
                flags_d   = flags_q | {filter_done, gray_done, mirror_done};
                if (out_we) begin
                    mem_we    = 1'b1;
                    mem_waddr = {row, col};
                    mem_wdata = out_pix;
                end
                if (filter_done) begin
                    state_d   = S_DUMP;
                    dp_addr_d = 12'd0;
                    dp_vld_d  = 1'b0;
                end else if (run_cnt_q == RUN_LAST) begin
                    state_d   = S_DUMP;
                    dp_addr_d = 12'd0;
                    dp_vld_d  = 1'b0;
                    tmo_d     = 1'b1;
                end
            end
            S_DUMP: begin
                // First DUMP cycle primes the output register with pixel 0.
                if (!dp_vld_q) begin
                    dp_pix_d  = mem[12'd0];
                    dp_addr_d = 12'd0;
                    dp_vld_d  = 1'b1;
                end else if (dp_ready) begin
                    if (dp_addr_q == ADDR_LAST) begin
                        state_d  = S_DONE;
                        dp_vld_d = 1'b0;
                    end else begin
                        dp_pix_d  = mem[dp_next];
                        dp_addr_d = dp_next;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel array has no reset so its contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ld_addr_q <= 12'd0;
            dp_addr_q <= 12'd0;
            run_cnt_q <= 16'd0;
            dp_pix_q  <= '0;
            dp_vld_q  <= 1'b0;
            flags_q   <= 3'b000;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_addr_q <= ld_addr_d;
            dp_addr_q <= dp_addr_d;
            run_cnt_q <= run_cnt_d;
            dp_pix_q  <= dp_pix_d;
            dp_vld_q  <= dp_vld_d;
            flags_q   <= flags_d;
            tmo_q     <= tmo_d;
        end
    end

endmodule
